// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: turns a stream of bitstream words into a serial
// ccff bit stream (MSB first) with a shift enable. It can optionally compare
// the bits falling out of the chain tail against the bits being loaded.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [7:0]        mismatch_cnt
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] buf_reg, buf_next;
  logic [BC_W-1:0]   buf_cnt_reg, buf_cnt_next;
  logic              verify_reg, verify_next;
  logic [7:0]        mismatch_reg, mismatch_next;

  // Derived per-cycle conditions shared by the datapath and the outputs.
  logic shifting;
  logic last_shift;
  logic accept;

  // A bit moves into the chain whenever the buffer holds something in LOAD.
  // The final shift closes the pass, so no word may be taken on that cycle.
  always_comb begin
    shifting   = (state_reg == S_LOAD) && (buf_cnt_reg != '0);
    last_shift = shifting && (bit_cnt_reg == BIT_W'(CHAIN_LEN - 1));
    word_ready = (state_reg == S_LOAD) && !last_shift &&
                 ((buf_cnt_reg == '0) ||
                  ((buf_cnt_reg == BC_W'(1)) && shifting));
    accept        = word_valid && word_ready;
    config_enable = shifting;
    ccff_head     = shifting ? buf_reg[WORD_W-1] : 1'b0;
    busy          = (state_reg == S_LOAD) || (state_reg == S_DONE);
    done          = (state_reg == S_DONE);
    mismatch_cnt  = mismatch_reg;
  end

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    buf_next      = buf_reg;
    buf_cnt_next  = buf_cnt_reg;
    verify_next   = verify_reg;
    mismatch_next = mismatch_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_LOAD;
          verify_next  = verify;
          bit_cnt_next = '0;
          buf_next     = '0;
          buf_cnt_next = '0;
          if (verify) begin
            mismatch_next = '0;
          end
        end
      end

      S_LOAD: begin
        if (shifting) begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          // Readback compare: the tail bit should equal the bit now entering.
          if (verify_reg && (ccff_tail != buf_reg[WORD_W-1]) &&
              (mismatch_reg != 8'hFF)) begin
            mismatch_next = mismatch_reg + 8'd1;
          end
        end
        if (last_shift) begin
          // Leftover bits of the current word are discarded.
          state_next   = S_DONE;
          buf_next     = '0;
          buf_cnt_next = '0;
        end else if (accept) begin
          buf_next     = word_data;
          buf_cnt_next = BC_W'(WORD_W);
        end else if (shifting) begin
          buf_next     = {buf_reg[WORD_W-2:0], 1'b0};
          buf_cnt_next = buf_cnt_reg - BC_W'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset mid-pass simply aborts.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      buf_reg      <= '0;
      buf_cnt_reg  <= '0;
      verify_reg   <= 1'b0;
      mismatch_reg <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      buf_reg      <= buf_next;
      buf_cnt_reg  <= buf_cnt_next;
      verify_reg   <= verify_next;
      mismatch_reg <= mismatch_next;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 48-bit chain model is driven from
// the loader outputs and feeds its tail back for readback compare.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       start, verify, word_valid;
  logic [7:0] word_data;
  logic       ccff_tail;
  logic       wr48, head48, en48, busy48, done48;
  logic [7:0] mm48;

  logic       start_b, valid_b;
  logic [7:0] data_b;
  logic       tail_b;
  logic       wr44, head44, en44, busy44, done44;
  logic [7:0] mm44;

  logic [47:0] chain = '0;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Results of the last pass
  int          en_cnt, gap_cnt, acc_cnt, lat, first_acc, done_cnt;
  logic [47:0] head_bits;
  logic        ready_in_done, busy_in_done;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(48), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify(verify),
    .word_data(word_data), .word_valid(word_valid), .word_ready(wr48),
    .ccff_head(head48), .config_enable(en48), .ccff_tail(ccff_tail),
    .busy(busy48), .done(done48), .mismatch_cnt(mm48)
  );

  ccff_chain_loader #(.CHAIN_LEN(44), .WORD_W(8)) dut44 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .verify(1'b0),
    .word_data(data_b), .word_valid(valid_b), .word_ready(wr44),
    .ccff_head(head44), .config_enable(en44), .ccff_tail(tail_b),
    .busy(busy44), .done(done44), .mismatch_cnt(mm44)
  );

  // Chain model: head enters bit 0, tail is bit 47; holds when not enabled.
  always @(posedge prog_clk) begin
    if (en48) chain <= {chain[46:0], head48};
  end
  assign ccff_tail = chain[47];
  assign tail_b    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pass: start, feed 6 words (optionally withholding word stall_word for
  // stall_n ready cycles), record shifts until done or abort after abort_at shifts.
  task automatic do_pass(input bit use44, input bit vmode, input logic [47:0] words,
                         input int stall_word, input int stall_n, input int abort_at);
    int wi = 0;
    int stall_left = stall_n;
    logic rdy, en, hd, dn, bz;
    en_cnt = 0; gap_cnt = 0; acc_cnt = 0; lat = -1; first_acc = -1;
    head_bits = '0; ready_in_done = 1'b1; busy_in_done = 1'b0;
    @(negedge prog_clk);
    if (use44) start_b = 1'b1; else begin start = 1'b1; verify = vmode; end
    @(negedge prog_clk);
    start = 1'b0; start_b = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rdy = use44 ? wr44  : wr48;
      en  = use44 ? en44  : en48;
      hd  = use44 ? head44 : head48;
      dn  = use44 ? done44 : done48;
      bz  = use44 ? busy44 : busy48;
      if (dn) begin
        lat = cyc - first_acc;
        ready_in_done = rdy;
        busy_in_done = bz;
        break;
      end
      if (en) begin
        en_cnt++;
        head_bits = {head_bits[46:0], hd};
      end else if (en_cnt > 0) begin
        gap_cnt++;
      end
      if (wi < 6) begin
        if (wi == stall_word && stall_left > 0 && rdy) begin
          stall_left--;
          word_valid = 1'b0; valid_b = 1'b0;
        end else begin
          if (use44) begin valid_b = 1'b1; data_b = words[47-8*wi -: 8]; end
          else begin word_valid = 1'b1; word_data = words[47-8*wi -: 8]; end
          if (rdy) begin
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            wi++;
          end
        end
      end else begin
        word_valid = 1'b0; valid_b = 1'b0;
      end
      if (abort_at > 0 && en_cnt == abort_at) begin
        pReset = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    word_valid = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    logic [47:0] w_a5, w_a4, w_mix, w_44;
    w_a5  = {6{8'hA5}};
    w_a4  = {8'hA4, {5{8'hA5}}};
    w_mix = 48'hC35A0FF09669;
    w_44  = 48'h112233445566;

    pReset = 1'b1; start = 0; verify = 0; word_valid = 0; word_data = 0;
    start_b = 0; valid_b = 0; data_b = 0;
    repeat (3) @(negedge prog_clk);
    check("rst_ready", wr48, 0);
    check("rst_head", head48, 0);
    check("rst_enable", en48, 0);
    check("rst_busy", busy48, 0);
    check("rst_done", done48, 0);
    check("rst_mismatch", mm48, 0);
    check("rst_busy44", busy44, 0);
    pReset = 1'b0;

    // Plain load of 0xA5 x6, no stalls
    do_pass(0, 0, w_a5, -1, 0, 0);
    $display("[TB] load A5x6: shifts=%0d gaps=%0d latency=%0d", en_cnt, gap_cnt, lat);
    check("a5_shifts", en_cnt, 48);
    check("a5_gaps", gap_cnt, 0);
    check("a5_stream", head_bits, w_a5);
    check("a5_latency", lat, 49);
    check("a5_accepted", acc_cnt, 6);
    check("a5_busy_done", busy_in_done, 1);
    check("a5_ready_done", ready_in_done, 0);
    @(negedge prog_clk);
    check("a5_chain", chain, w_a5);
    check("a5_done_single", done48, 0);
    check("a5_idle_busy", busy48, 0);

    // Verify pass with matching data
    do_pass(0, 1, w_a5, -1, 0, 0);
    $display("[TB] verify A5x6: mismatch=%0d", mm48);
    check("vfy_match_cnt", mm48, 0);

    // Verify pass with one flipped bit in the first word
    do_pass(0, 1, w_a4, -1, 0, 0);
    $display("[TB] verify A4+A5x5: mismatch=%0d", mm48);
    check("vfy_onebit_cnt", mm48, 1);

    // A load pass leaves the count alone
    do_pass(0, 0, w_a5, -1, 0, 0);
    $display("[TB] load after verify: mismatch=%0d", mm48);
    check("load_holds_cnt", mm48, 1);
    check("reload_chain", chain, w_a5);

    // Withhold the third word for 3 ready cycles
    do_pass(0, 0, w_mix, 2, 3, 0);
    $display("[TB] stalled load: shifts=%0d gaps=%0d latency=%0d", en_cnt, gap_cnt, lat);
    check("stall_shifts", en_cnt, 48);
    check("stall_gaps", gap_cnt, 3);
    check("stall_latency", lat, 52);
    check("stall_stream", head_bits, w_mix);
    @(negedge prog_clk);
    check("stall_chain", chain, w_mix);

    // Short chain: last 4 bits of the 6th word are dropped
    do_pass(1, 0, w_44, -1, 0, 0);
    $display("[TB] chain44 load: shifts=%0d accepted=%0d latency=%0d", en_cnt, acc_cnt, lat);
    check("c44_shifts", en_cnt, 44);
    check("c44_accepted", acc_cnt, 6);
    check("c44_stream", head_bits, {4'h0, w_44[47:4]});
    check("c44_latency", lat, 45);
    check("c44_ready_done", ready_in_done, 0);

    // Reset after the 20th shift aborts the pass
    do_pass(0, 0, w_a5, -1, 0, 20);
    @(negedge prog_clk);
    $display("[TB] abort at shift %0d: busy=%0d enable=%0d", en_cnt, busy48, en48);
    check("abort_ready", wr48, 0);
    check("abort_head", head48, 0);
    check("abort_enable", en48, 0);
    check("abort_busy", busy48, 0);
    check("abort_done", done48, 0);
    check("abort_mismatch", mm48, 0);
    pReset = 1'b0;
    done_cnt = 0;
    repeat (60) begin
      @(negedge prog_clk);
      if (done48) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    do_pass(0, 0, w_mix, -1, 0, 0);
    $display("[TB] load after abort: shifts=%0d latency=%0d", en_cnt, lat);
    check("post_abort_shifts", en_cnt, 48);
    check("post_abort_latency", lat, 49);
    @(negedge prog_clk);
    check("post_abort_chain", chain, w_mix);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 48: number of configuration flops in the downstream ccff chain (12 size-8 mux memories x 4 bits).
REQ-002 SHALL have parameter WORD_W, default 8: width of the bitstream input word.
REQ-003 SHALL have a single clock and a synchronous, active-high reset; the clock and reset are the codebase's prog_clk and pReset.
REQ-004 prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-005 pReset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request for one load pass; honoured only in IDLE.
REQ-007 verify  input  1  pass mode, sampled with start: 0 = load, 1 = load with readback compare.
REQ-008 word_data  input  WORD_W  bitstream word; MSB is shifted first.
REQ-009 word_valid  input  1  word_data is valid.
REQ-010 word_ready  output  1  loader accepts word_data this cycle.
REQ-011 ccff_head  output  1  serial configuration bit to the chain head.
REQ-012 config_enable  output  1  chain shift enable; high only on cycles where ccff_head carries a valid bit.
REQ-013 ccff_tail  input  1  serial output from the chain tail.
REQ-014 busy  output  1  high in LOAD and DONE.
REQ-015 done  output  1  single-cycle pulse at the end of a pass.
REQ-016 mismatch_cnt  output  8  saturating readback error count from the last verify pass.

Function
REQ-017 SHALL implement the states IDLE, LOAD and DONE.
REQ-018 IDLE -> LOAD on start=1; on that edge the block SHALL latch verify, clear bit_cnt and the shift buffer, and clear mismatch_cnt if verify=1.
REQ-019 start SHALL be ignored in LOAD and DONE.
REQ-020 Transfer rule: a word is accepted when word_valid=1 and word_ready=1.
REQ-021 word_ready SHALL be high in LOAD when the buffer is empty or holds exactly 1 bit that is being shifted this cycle, so back-to-back words produce no bubble.
REQ-022 word_ready SHALL be 0 in IDLE and DONE.
REQ-023 An accepted word SHALL load into a WORD_W shift buffer; the first bit appears on ccff_head the cycle after acceptance.
REQ-024 Each cycle the buffer is non-empty in LOAD, the block SHALL:
  - drive ccff_head = buffer MSB and config_enable = 1;
  - shift the buffer left by 1;
  - increment bit_cnt (width clog2(CHAIN_LEN+1)).
REQ-025 When the buffer is empty (upstream stall), config_enable SHALL be 0 and ccff_head SHALL be 0, so the chain holds its contents.
REQ-026 On the cycle the CHAIN_LEN-th bit is shifted, the block SHALL go to DONE and drop any remaining bits of the current word.
REQ-027 No further word SHALL be accepted after the CHAIN_LEN-th bit is shifted.
REQ-028 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-029 Verify compare: in a verify pass, on every cycle with config_enable=1, if ccff_tail != ccff_head then mismatch_cnt SHALL increment, saturating at 255.
REQ-030 mismatch_cnt SHALL hold its value in load passes and after a verify pass until the next verify start.
REQ-031 Latency: from acceptance of the first word to done = CHAIN_LEN+1 cycles with no stalls; each stall cycle adds 1 cycle.

Reset
REQ-032 While pReset=1, at each rising edge the block SHALL set:
  - state = IDLE;
  - bit_cnt, the buffer and the latched verify = 0;
  - word_ready, ccff_head, config_enable, busy, done = 0;
  - mismatch_cnt = 0.
REQ-033 pReset asserted mid-LOAD SHALL abort the pass with no done pulse; the chain contents are left partially shifted.

Verification
REQ-034 Reset, then start verify=0 with 6 back-to-back words 0xA5 -> config_enable high 48 consecutive cycles, ccff_head = 1,0,1,0,0,1,0,1 repeated, done pulse 49 cycles after the first acceptance.
REQ-035 Model a 48-flop chain from the block's outputs; load 0xA5 x6, then verify pass with 0xA5 x6 -> mismatch_cnt = 0.
REQ-036 After loading 0xA5 x6, verify pass with 0xA4 followed by 0xA5 x5 -> mismatch_cnt = 1.
REQ-037 Drop word_valid for 3 cycles after the 2nd word -> config_enable low for exactly those 3 cycles, done delayed by 3, chain contents equal the no-stall case.
REQ-038 CHAIN_LEN=44 with 6 words supplied -> 44 shifts, 6th word's 4 LSBs discarded, word_ready low in DONE.
REQ-039 Assert pReset at shift 20 -> next edge: all outputs 0 and state IDLE, no done pulse; a subsequent start operates normally.
